// File: rtl/audio_delay_line_pkg.sv
// Shared types, default widths and a constant log2 helper for the audio delay line.
package audio_delay_line_pkg;

  localparam int unsigned DATALEN_DEF = 16;
  localparam int unsigned ADDRLEN_DEF = 14;

  // Native geometry of one SB_SPRAM256KA macro.
  localparam int unsigned SPRAM_AW = 14;
  localparam int unsigned SPRAM_DW = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int unsigned clog2_f(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/SB_SPRAM256KA.sv
// Behavioural model of the iCE40UP 16K x 16 single-port RAM macro.
// Read data is registered: DATAOUT updates on the clock edge that samples the
// address. POWEROFF is active low (1 = powered).
module SB_SPRAM256KA (
  input  logic [13:0] ADDRESS,
  input  logic [15:0] DATAIN,
  input  logic [3:0]  MASKWREN,
  input  logic        WREN,
  input  logic        CHIPSELECT,
  input  logic        CLOCK,
  input  logic        STANDBY,
  input  logic        SLEEP,
  input  logic        POWEROFF,
  output logic [15:0] DATAOUT
);

  logic [15:0] mem_q [16384];

  // Nibble-masked write or registered read when selected and awake.
  always_ff @(posedge CLOCK) begin
    if (CHIPSELECT && !STANDBY && !SLEEP && POWEROFF) begin
      if (WREN) begin
        for (int n = 0; n < 4; n++) begin
          if (MASKWREN[n]) begin
            mem_q[ADDRESS][n*4 +: 4] <= DATAIN[n*4 +: 4];
          end
        end
      end else begin
        DATAOUT <= mem_q[ADDRESS];
      end
    end
  end

endmodule

// File: rtl/spram_bank_array.sv
// NBANKS SPRAM macros behind a bank decoder. The bank of each read is latched
// alongside the macro's own output register so the readback mux stays aligned
// with the data even though the live address has already moved on.
module spram_bank_array
  import audio_delay_line_pkg::*;
#(
  parameter int unsigned DATALEN = DATALEN_DEF,
  parameter int unsigned ADDRLEN = ADDRLEN_DEF,
  parameter int unsigned NBANKS  = 4
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic [ADDRLEN+clog2_f(NBANKS)-1:0]  addr_i,
  input  logic [DATALEN-1:0]                  wdata_i,
  input  logic                                wr_i,
  input  logic                                rd_i,
  output logic [DATALEN-1:0]                  rdata_c_o
);

  localparam int unsigned BSEL_W  = clog2_f(NBANKS);
  localparam int unsigned BSEL_VW = (BSEL_W == 0) ? 1 : BSEL_W;
  localparam int unsigned MEMLEN  = ADDRLEN + BSEL_W;

  logic [BSEL_VW-1:0]               bsel_c;
  logic [BSEL_VW-1:0]               bsel_q;
  logic [SPRAM_AW-1:0]              waddr_c;
  logic [SPRAM_DW-1:0]              wdata_c;
  logic [NBANKS-1:0][SPRAM_DW-1:0]  dout_c;

  // Bank select comes from the top address bits; a single bank is always bank 0.
  if (BSEL_W == 0) begin : g_one_bank
    assign bsel_c = '0;
  end else begin : g_multi_bank
    assign bsel_c = addr_i[MEMLEN-1 -: BSEL_W];
  end

  assign waddr_c = SPRAM_AW'(addr_i[ADDRLEN-1:0]);
  assign wdata_c = SPRAM_DW'(wdata_i);

  // Remember which bank the outstanding read went to.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bsel_q <= '0;
    end else if (rd_i) begin
      bsel_q <= bsel_c;
    end
  end

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    logic cs_c;
    // Only the addressed bank is enabled, and only while an access is issued.
    assign cs_c = (wr_i || rd_i) && (bsel_c == BSEL_VW'(b));

    SB_SPRAM256KA u_spram (
      .ADDRESS    (waddr_c),
      .DATAIN     (wdata_c),
      .MASKWREN   (4'b1111),
      .WREN       (wr_i),
      .CHIPSELECT (cs_c),
      .CLOCK      (clk),
      .STANDBY    (1'b0),
      .SLEEP      (1'b0),
      .POWEROFF   (1'b1),
      .DATAOUT    (dout_c[b])
    );
  end

  // Readback mux driven by the registered bank select.
  always_comb begin
    rdata_c_o = '0;
    for (int b = 0; b < int'(NBANKS); b++) begin
      if (bsel_q == BSEL_VW'(b)) begin
        rdata_c_o = DATALEN'(dout_c[b]);
      end
    end
  end

endmodule

// File: rtl/audio_delay_line.sv
// Multi-tap audio delay line: each accepted sample is written at wr_ptr, then
// NTAPS older samples are read back at wr_ptr - delay_i and published together.
module audio_delay_line
  import audio_delay_line_pkg::*;
#(
  parameter int unsigned DATALEN = DATALEN_DEF,
  parameter int unsigned ADDRLEN = ADDRLEN_DEF,
  parameter int unsigned NBANKS  = 4,
  parameter int unsigned NTAPS   = 2
) (
  input  logic                                       clk,
  input  logic                                       resetn,
  input  logic                                       in_valid,
  input  logic [DATALEN-1:0]                         in_sample,
  output logic                                       in_ready,
  input  logic [NTAPS*(ADDRLEN+clog2_f(NBANKS))-1:0] delay,
  output logic                                       out_valid,
  output logic [NTAPS*DATALEN-1:0]                   out_sample,
  output logic                                       overrun
);

  localparam int unsigned MEMLEN = ADDRLEN + clog2_f(NBANKS);
  localparam int unsigned TAP_W  = (NTAPS > 1) ? clog2_f(NTAPS) : 1;

  state_e                      state_q, state_d;
  logic [MEMLEN-1:0]           wr_ptr_q, wr_ptr_d;
  logic [DATALEN-1:0]          sample_q, sample_d;
  logic [NTAPS*MEMLEN-1:0]     delay_q, delay_d;
  logic [TAP_W-1:0]            tap_q, tap_d;
  logic [TAP_W-1:0]            cap_tap_q;
  logic                        cap_vld_q;
  logic [NTAPS*DATALEN-1:0]    taps_q, taps_d;
  logic [NTAPS*DATALEN-1:0]    out_sample_q, out_sample_d;
  logic                        out_valid_q, out_valid_d;
  logic                        overrun_q, overrun_d;
  logic                        in_ready_q, in_ready_d;

  logic [MEMLEN-1:0]           tap_delay_c;
  logic [MEMLEN-1:0]           mem_addr_c;
  logic                        mem_wr_c;
  logic                        mem_rd_c;
  logic [DATALEN-1:0]          rdata_c;

  // Delay of the tap currently being read.
  always_comb begin
    tap_delay_c = '0;
    for (int i = 0; i < int'(NTAPS); i++) begin
      if (tap_q == TAP_W'(i)) begin
        tap_delay_c = delay_q[i*MEMLEN +: MEMLEN];
      end
    end
  end

  // Next-state, memory control and status logic.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    sample_d     = sample_q;
    delay_d      = delay_q;
    tap_d        = tap_q;
    out_valid_d  = 1'b0;
    out_sample_d = out_sample_q;
    overrun_d    = overrun_q;
    mem_wr_c     = 1'b0;
    mem_rd_c     = 1'b0;
    mem_addr_c   = wr_ptr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sample_d = in_sample;
          delay_d  = delay;
          state_d  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        mem_wr_c = 1'b1;
        tap_d    = '0;
        state_d  = ST_READ;
      end
      ST_READ: begin
        mem_rd_c   = 1'b1;
        mem_addr_c = wr_ptr_q - tap_delay_c;
        if (tap_q == TAP_W'(NTAPS - 1)) begin
          state_d = ST_WAIT;
        end else begin
          tap_d = tap_q + TAP_W'(1);
        end
      end
      ST_WAIT: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid_d  = 1'b1;
        out_sample_d = taps_q;
        wr_ptr_d     = wr_ptr_q + MEMLEN'(1);
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A strobe while busy is dropped and flagged until reset.
    if (in_valid && !in_ready_q) begin
      overrun_d = 1'b1;
    end
  end

  assign in_ready_d = (state_d == ST_IDLE);

  // Read data lands one cycle after its read; steer it into that tap's slot.
  always_comb begin
    taps_d = taps_q;
    for (int i = 0; i < int'(NTAPS); i++) begin
      if (cap_vld_q && (cap_tap_q == TAP_W'(i))) begin
        taps_d[i*DATALEN +: DATALEN] = rdata_c;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      sample_q     <= '0;
      delay_q      <= '0;
      tap_q        <= '0;
      cap_tap_q    <= '0;
      cap_vld_q    <= 1'b0;
      taps_q       <= '0;
      out_sample_q <= '0;
      out_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      sample_q     <= sample_d;
      delay_q      <= delay_d;
      tap_q        <= tap_d;
      cap_tap_q    <= tap_q;
      cap_vld_q    <= mem_rd_c;
      taps_q       <= taps_d;
      out_sample_q <= out_sample_d;
      out_valid_q  <= out_valid_d;
      overrun_q    <= overrun_d;
      in_ready_q   <= in_ready_d;
    end
  end

  spram_bank_array #(
    .DATALEN (DATALEN),
    .ADDRLEN (ADDRLEN),
    .NBANKS  (NBANKS)
  ) u_banks (
    .clk       (clk),
    .resetn    (resetn),
    .addr_i    (mem_addr_c),
    .wdata_i   (sample_q),
    .wr_i      (mem_wr_c),
    .rd_i      (mem_rd_c),
    .rdata_c_o (rdata_c)
  );

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_sample = out_sample_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_audio_delay_line.sv
// Bench for audio_delay_line, built with a reduced per-bank depth (ADDRLEN=6,
// 4 banks, 256 words) so pointer wrap and bank crossings are reachable quickly.
module tb_audio_delay_line;

  localparam int DW    = 16;
  localparam int AL    = 6;
  localparam int NB    = 4;
  localparam int NT    = 2;
  localparam int ML    = 8;
  localparam int DEPTH = 256;

  logic              clk = 1'b0;
  logic              resetn;
  logic              in_valid;
  logic [DW-1:0]     in_sample;
  logic              in_ready;
  logic [NT*ML-1:0]  delay;
  logic              out_valid;
  logic [NT*DW-1:0]  out_sample;
  logic              overrun;

  always #5 clk = ~clk;

  audio_delay_line #(
    .DATALEN (DW),
    .ADDRLEN (AL),
    .NBANKS  (NB),
    .NTAPS   (NT)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_sample  (in_sample),
    .in_ready   (in_ready),
    .delay      (delay),
    .out_valid  (out_valid),
    .out_sample (out_sample),
    .overrun    (overrun)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: a circular buffer of everything written, plus a pointer.
  logic [15:0] mem_m [DEPTH];
  bit          wr_m  [DEPTH];
  int          wptr_m;
  logic [15:0] exp0, exp1;
  bit          chk0, chk1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_txn(input logic [15:0] s, input int d0, input int d1);
    int a0, a1;
    mem_m[wptr_m] = s;
    wr_m[wptr_m]  = 1'b1;
    a0 = (wptr_m - d0 + DEPTH) % DEPTH;
    a1 = (wptr_m - d1 + DEPTH) % DEPTH;
    chk0 = wr_m[a0];
    exp0 = mem_m[a0];
    chk1 = wr_m[a1];
    exp1 = mem_m[a1];
    wptr_m = (wptr_m + 1) % DEPTH;
  endtask

  // One transaction; optional duplicate strobe on the cycle after acceptance.
  task automatic send(input logic [15:0] s, input logic [7:0] d0, input logic [7:0] d1, input bit dup);
    int lat;
    bit got;
    @(negedge clk);
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    in_sample = s;
    delay     = {d1, d0};
    model_txn(s, int'(d0), int'(d1));
    @(posedge clk);
    #1;
    delay = 16'($urandom);
    lat = 0;
    got = 1'b0;
    if (dup) begin
      in_sample = ~s;
      chk("in_ready_busy", 64'(in_ready), 64'd0);
      @(posedge clk);
      lat++;
      #1;
      chk("overrun_set", 64'(overrun), 64'd1);
    end
    in_valid = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      got = out_valid;
    end
    chk("latency", 64'(lat), 64'd5);
    if (chk0) chk("tap0", 64'(out_sample[15:0]), 64'(exp0));
    if (chk1) chk("tap1", 64'(out_sample[31:16]), 64'(exp1));
    @(posedge clk);
    #1;
    chk("out_valid_one_cycle", 64'(out_valid), 64'd0);
    if (chk0) chk("tap0_hold", 64'(out_sample[15:0]), 64'(exp0));
  endtask

  task automatic send_rand();
    send(16'($urandom), 8'($urandom), 8'($urandom), 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] old_word;
    int saw;
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_sample = '0;
    delay     = '0;
    wptr_m    = 0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_m[i]  = 1'b0;
      mem_m[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sample", 64'(out_sample), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);

    // Three writes, tap0 delay 0, tap1 delay 2.
    send(16'h1111, 8'd0, 8'd2, 1'b0);
    send(16'h2222, 8'd0, 8'd2, 1'b0);
    send(16'h3333, 8'd0, 8'd2, 1'b0);
    chk("basic_tap0", 64'(out_sample[15:0]), 64'h3333);
    chk("basic_tap1", 64'(out_sample[31:16]), 64'h1111);
    chk("overrun_clear", 64'(overrun), 64'd0);

    // Back-to-back strobes: second dropped, pointer advances once.
    send(16'hBEEF, 8'd0, 8'd1, 1'b1);
    send(16'h0F0F, 8'd1, 8'd2, 1'b0);
    chk("drop_prev", 64'(out_sample[15:0]), 64'hBEEF);
    chk("drop_prev2", 64'(out_sample[31:16]), 64'h3333);
    chk("overrun_sticky", 64'(overrun), 64'd1);

    // Fill up to the bank 0 / bank 1 boundary, then cross it.
    while (wptr_m != 8'h3F) send_rand();
    send(16'hA5A5, 8'd0, 8'd0, 1'b0);
    send(16'h5A5A, 8'd1, 8'h40, 1'b0);
    chk("bank_cross", 64'(out_sample[15:0]), 64'hA5A5);

    // Run until the pointer wraps, then read the oldest word.
    while (wptr_m != 0) send_rand();
    old_word = mem_m[1];
    send(16'hC3C3, 8'hFF, 8'h00, 1'b0);
    chk("wrap_oldest", 64'(out_sample[15:0]), 64'(old_word));
    chk("wrap_new", 64'(out_sample[31:16]), 64'hC3C3);

    repeat (60) send_rand();

    // Reset asserted while the first tap is being read.
    @(negedge clk);
    in_valid  = 1'b1;
    in_sample = 16'h7E7E;
    delay     = {8'd3, 8'd1};
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    mem_m[wptr_m] = 16'h7E7E;
    wr_m[wptr_m]  = 1'b1;
    @(posedge clk);
    #1;
    resetn = 1'b0;
    wptr_m = 0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_out_sample", 64'(out_sample), 64'd0);
    chk("mid_rst_overrun", 64'(overrun), 64'd0);
    saw = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (out_valid) saw++;
    end
    chk("mid_rst_no_strobe", 64'(saw), 64'd0);

    // Pointer restarts at 0: older words are found at absolute addresses.
    send(16'h1234, 8'd0, 8'd1, 1'b0);
    send(16'h5678, 8'd1, 8'd2, 1'b0);
    chk("post_rst_tap0", 64'(out_sample[15:0]), 64'h1234);
    repeat (30) send_rand();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
